mem_arbiter: RTL and testbench

Two-port arbiter that shares the single main-memory line port between the instruction cache (line fills) and the data cache (line fills and write-backs). It sits between the cache miss logic of the Abejaruco core and the main memory model. It serialises requests, grants contending requesters round-robin, and returns each line through a registered ready pulse.

---
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory line port between icache fills
// and dcache fills/write-backs; each line is returned with a one-cycle ready pulse.
module mem_arbiter #(
  parameter int unsigned ADDRESS_WIDTH   = 32,
  parameter int unsigned CACHE_LINE_SIZE = 128
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ic_req,
  input  logic [ADDRESS_WIDTH-1:0]   ic_addr,
  output logic                       ic_ready,
  output logic [CACHE_LINE_SIZE-1:0] ic_data,
  input  logic                       dc_req,
  input  logic                       dc_write,
  input  logic [ADDRESS_WIDTH-1:0]   dc_addr,
  input  logic [CACHE_LINE_SIZE-1:0] dc_wdata,
  output logic                       dc_ready,
  output logic [CACHE_LINE_SIZE-1:0] dc_rdata,
  output logic                       mem_req,
  output logic                       mem_write,
  output logic [ADDRESS_WIDTH-1:0]   mem_addr,
  output logic [CACHE_LINE_SIZE-1:0] mem_wdata,
  input  logic [CACHE_LINE_SIZE-1:0] mem_rdata,
  input  logic                       mem_ready
);

  localparam int unsigned OFFSET_BITS = $clog2(CACHE_LINE_SIZE / 8);
  localparam logic [ADDRESS_WIDTH-1:0] LINE_MASK =
    {{(ADDRESS_WIDTH - OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESPOND
  } state_t;

  state_t                     state, state_next;
  logic                       grant_ic, grant_ic_next;  // last grant: 1 = icache, 0 = dcache
  logic                       pick_ic;
  logic                       mem_req_next, mem_write_next;
  logic [ADDRESS_WIDTH-1:0]   mem_addr_next;
  logic [CACHE_LINE_SIZE-1:0] mem_wdata_next, ic_data_next, dc_rdata_next;
  logic                       ic_ready_next, dc_ready_next;

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant_ic  <= 1'b0;
      mem_req   <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ic_ready  <= 1'b0;
      dc_ready  <= 1'b0;
      ic_data   <= '0;
      dc_rdata  <= '0;
    end else begin
      state     <= state_next;
      grant_ic  <= grant_ic_next;
      mem_req   <= mem_req_next;
      mem_write <= mem_write_next;
      mem_addr  <= mem_addr_next;
      mem_wdata <= mem_wdata_next;
      ic_ready  <= ic_ready_next;
      dc_ready  <= dc_ready_next;
      ic_data   <= ic_data_next;
      dc_rdata  <= dc_rdata_next;
    end
  end

  // Next-state and next-output logic; on a tie the requester not granted last wins
  always_comb begin
    state_next     = state;
    grant_ic_next  = grant_ic;
    mem_req_next   = mem_req;
    mem_write_next = mem_write;
    mem_addr_next  = mem_addr;
    mem_wdata_next = mem_wdata;
    ic_data_next   = ic_data;
    dc_rdata_next  = dc_rdata;
    ic_ready_next  = 1'b0;
    dc_ready_next  = 1'b0;
    pick_ic        = ic_req && (!dc_req || !grant_ic);

    case (state)
      IDLE: begin
        if (ic_req || dc_req) begin
          state_next    = BUSY;
          grant_ic_next = pick_ic;
          mem_req_next  = 1'b1;
          if (pick_ic) begin
            mem_write_next = 1'b0;
            mem_addr_next  = ic_addr & LINE_MASK;
          end else begin
            mem_write_next = dc_write;
            mem_addr_next  = dc_addr & LINE_MASK;
            mem_wdata_next = dc_wdata;
          end
        end
      end
      BUSY: begin
        if (mem_ready) begin
          state_next    = RESPOND;
          mem_req_next  = 1'b0;
          ic_ready_next = grant_ic;
          dc_ready_next = !grant_ic;
          if (!mem_write) begin
            if (grant_ic) ic_data_next  = mem_rdata;
            else          dc_rdata_next = mem_rdata;
          end
        end
      end
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios then randomized rounds,
// checked against a transaction-level model of grant order and returned lines.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          ic_req, ic_ready, dc_req, dc_write, dc_ready;
  logic          mem_req, mem_write, mem_ready;
  logic [AW-1:0] ic_addr, dc_addr, mem_addr;
  logic [LW-1:0] ic_data, dc_wdata, dc_rdata, mem_wdata, mem_rdata;

  mem_arbiter #(.ADDRESS_WIDTH(AW), .CACHE_LINE_SIZE(LW)) dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ready(ic_ready), .ic_data(ic_data),
    .dc_req(dc_req), .dc_write(dc_write), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_ready(dc_ready), .dc_rdata(dc_rdata),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic          is_ic;
    logic [LW-1:0] ic_data;
    logic [LW-1:0] dc_rdata;
  } rsp_exp_t;

  mem_exp_t      mem_q[$];
  rsp_exp_t      rsp_q[$];
  logic          m_last_ic;
  logic [LW-1:0] m_ic_data, m_dc_rdata;

  int lat = 1;
  int rdy_seen = 0;
  int rdy_cyc = 0;
  int gap = 0;
  int low_run = 0;

  // Memory contents are a fixed function of the line address
  function automatic logic [LW-1:0] line_val(input logic [AW-1:0] a);
    return {a ^ 32'hA5A5_0F0F, a + 32'h1234_5678, ~a, a * 32'd3 + 32'h33};
  endfunction

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one served transaction, in service order
  task automatic model_serve(input logic is_ic, input logic write, input logic [AW-1:0] addr,
                             input logic [LW-1:0] wdata);
    mem_exp_t m;
    rsp_exp_t r;
    m.write = is_ic ? 1'b0 : write;
    m.addr  = addr & ~32'hF;
    m.wdata = wdata;
    mem_q.push_back(m);
    if (!m.write) begin
      if (is_ic) m_ic_data  = line_val(m.addr);
      else       m_dc_rdata = line_val(m.addr);
    end
    m_last_ic  = is_ic;
    r.is_ic    = is_ic;
    r.ic_data  = m_ic_data;
    r.dc_rdata = m_dc_rdata;
    rsp_q.push_back(r);
  endtask

  task automatic ic_txn(input logic [AW-1:0] a, input int dly);
    bit done = 0;
    repeat (dly) @(negedge clk);
    ic_addr = a;
    ic_req  = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (ic_ready) done = 1;
    end
    ic_req = 1'b0;
    check("ic_ready_timeout", LW'(done), LW'(1));
  endtask

  task automatic dc_txn(input logic [AW-1:0] a, input logic w, input logic [LW-1:0] wd, input int dly);
    bit done = 0;
    repeat (dly) @(negedge clk);
    dc_addr  = a;
    dc_write = w;
    dc_wdata = wd;
    dc_req   = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (dc_ready) done = 1;
    end
    dc_req = 1'b0;
    check("dc_ready_timeout", LW'(done), LW'(1));
  endtask

  // mode: 0 ic only, 1 dc only, 2 tie, 3 ic then dc one cycle later, 4 dc then ic
  task automatic round(input int mode, input logic [AW-1:0] ia, input logic [AW-1:0] da,
                       input logic dw, input logic [LW-1:0] wd);
    bit ic_first;
    case (mode)
      0: begin
        model_serve(1'b1, 1'b0, ia, '0);
        ic_txn(ia, 0);
      end
      1: begin
        model_serve(1'b0, dw, da, wd);
        dc_txn(da, dw, wd, 0);
      end
      default: begin
        ic_first = (mode == 2) ? !m_last_ic : (mode == 3);
        if (ic_first) begin
          model_serve(1'b1, 1'b0, ia, '0);
          model_serve(1'b0, dw, da, wd);
        end else begin
          model_serve(1'b0, dw, da, wd);
          model_serve(1'b1, 1'b0, ia, '0);
        end
        fork
          ic_txn(ia, (mode == 4) ? 1 : 0);
          dc_txn(da, dw, wd, (mode == 3) ? 1 : 0);
        join
      end
    endcase
    repeat (1 + $urandom_range(0, 2)) @(negedge clk);
  endtask

  // Memory model: mem_ready pulses L cycles after it first sees mem_req
  initial begin
    int  cnt;
    bit  active;
    cnt       = 0;
    active    = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (reset) begin
        active = 0;
      end else if (active) begin
        cnt--;
        if (cnt == 0) begin
          active    = 0;
          mem_ready = 1'b1;
          if (!mem_write) mem_rdata = line_val(mem_addr);
        end
      end else if (mem_req) begin
        active = 1;
        cnt    = lat;
      end
    end
  end

  // Monitor: memory-side transactions and requester responses
  initial begin
    bit       prev_req;
    mem_exp_t m;
    rsp_exp_t r;
    prev_req = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req = 0;
      end else begin
        if (mem_req && !prev_req) begin
          gap = low_run;
          if (mem_q.size() == 0) begin
            check("unexpected_mem_req", LW'(mem_req), LW'(0));
          end else begin
            m = mem_q.pop_front();
            check("mem_write", LW'(mem_write), LW'(m.write));
            check("mem_addr", LW'(mem_addr), LW'(m.addr));
            if (m.write) check("mem_wdata", mem_wdata, m.wdata);
          end
        end
        if (mem_req) low_run = 0;
        else         low_run++;
        prev_req = mem_req;
        if (ic_ready && dc_ready) check("both_ready", LW'(1), LW'(0));
        if (ic_ready || dc_ready) begin
          rdy_seen++;
          rdy_cyc = cyc;
          if (rsp_q.size() == 0) begin
            check("unexpected_ready", LW'(1), LW'(0));
          end else begin
            r = rsp_q.pop_front();
            check("rsp_port_ic", LW'(ic_ready), LW'(r.is_ic));
            check("ic_data", ic_data, r.ic_data);
            check("dc_rdata", dc_rdata, r.dc_rdata);
          end
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, seen0;
    reset    = 1'b1;
    ic_req   = 1'b0;
    ic_addr  = '0;
    dc_req   = 1'b0;
    dc_write = 1'b0;
    dc_addr  = '0;
    dc_wdata = '0;
    m_last_ic  = 1'b0;
    m_ic_data  = '0;
    m_dc_rdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Quiet after reset
    repeat (5) @(negedge clk);
    check("rst_mem_req", LW'(mem_req), LW'(0));
    check("rst_mem_write", LW'(mem_write), LW'(0));
    check("rst_mem_addr", LW'(mem_addr), LW'(0));
    check("rst_mem_wdata", mem_wdata, '0);
    check("rst_ic_ready", LW'(ic_ready), LW'(0));
    check("rst_dc_ready", LW'(dc_ready), LW'(0));
    check("rst_ic_data", ic_data, '0);
    check("rst_dc_rdata", dc_rdata, '0);

    // icache read, memory latency 4: ready 5 cycles after the sampling edge
    lat = 4;
    c0  = cyc;
    round(0, 32'h0000_0014, '0, 1'b0, '0);
    check("ic_latency", LW'(rdy_cyc - c0 - 1), LW'(5));

    // dcache read then write-back; rdata must survive the write
    lat = 2;
    round(1, '0, 32'h0000_0208, 1'b0, '0);
    lat = 3;
    round(1, '0, 32'h0000_0100, 1'b1, {4{32'hDEADBEEF}});

    // Ties: order follows the last grant; two idle cycles between transfers
    lat = 2;
    round(2, 32'h0000_0200, 32'h0000_0300, 1'b0, '0);
    check("tie_gap", LW'(gap), LW'(2));
    round(2, 32'h0000_0210, 32'h0000_0310, 1'b1, {4{32'h0BAD_F00D}});
    check("tie_gap2", LW'(gap), LW'(2));

    // Reset mid-transfer drops mem_req at once and produces no ready
    lat   = 6;
    seen0 = rdy_seen;
    mem_q.push_back('{write: 1'b0, addr: 32'h0000_0040, wdata: '0});
    ic_addr = 32'h0000_0044;
    ic_req  = 1'b1;
    repeat (3) @(negedge clk);
    check("busy_mem_req", LW'(mem_req), LW'(1));
    reset = 1'b1;
    #1;
    check("async_mem_req", LW'(mem_req), LW'(0));
    check("async_mem_addr", LW'(mem_addr), LW'(0));
    check("async_ic_data", ic_data, '0);
    check("async_dc_rdata", dc_rdata, '0);
    ic_req = 1'b0;
    repeat (2) @(negedge clk);
    reset      = 1'b0;
    m_last_ic  = 1'b0;
    m_ic_data  = '0;
    m_dc_rdata = '0;
    repeat (8) @(negedge clk);
    check("no_ready_after_reset", LW'(rdy_seen), LW'(seen0));
    lat = 2;
    round(0, 32'h0000_0084, '0, 1'b0, '0);
    round(2, 32'h0000_0090, 32'h0000_00A0, 1'b0, '0);

    // Stray mem_ready in IDLE is ignored
    seen0     = rdy_seen;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_mem_ready_no_rsp", LW'(rdy_seen), LW'(seen0));
    check("idle_mem_ready_no_req", LW'(mem_req), LW'(0));
    round(0, 32'h0000_0ABC, '0, 1'b0, '0);

    // Randomized rounds
    for (int i = 0; i < 150; i++) begin
      lat = $urandom_range(1, 5);
      round($urandom_range(0, 4), $urandom, $urandom, 1'($urandom_range(0, 1)),
            {$urandom, $urandom, $urandom, $urandom});
    end

    repeat (4) @(negedge clk);
    check("mem_q_drained", LW'(mem_q.size()), LW'(0));
    check("rsp_q_drained", LW'(rsp_q.size()), LW'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
